// File: rtl/imm_gen_pkg.sv
// ----------------------------------------------------------------------------
// imm_gen_pkg
// Shared types and constants for the immediate generator pipeline:
//   imm_fmt_e  - 3-bit immediate format code reported on out_fmt
//   OP_*       - RISC-V major opcodes (inst[6:0]) that the decoder recognises
//   dec_res_t  - decoder result {imm, fmt, illegal}; imm is held at the
//                widest legal XLEN (64) and already sign-extended, so a
//                narrower pipeline simply keeps the low XLEN bits
//   occ_e      - occupancy states of the two-entry output skid buffer
// ----------------------------------------------------------------------------
package imm_gen_pkg;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } imm_fmt_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  // RV64-only word forms
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_OP32   = 7'b0111011;

  localparam int IMM_MAX_W = 64;

  typedef struct packed {
    logic [IMM_MAX_W-1:0] imm;
    imm_fmt_e             fmt;
    logic                 illegal;
  } dec_res_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/imm_decode.sv
// ----------------------------------------------------------------------------
// imm_decode
// Purely combinational RISC-V immediate decoder.
//   Parameter XLEN (32 or 64) only decides whether the RV64 word opcodes
//   (OP-IMM-32, OP-32) are legal; the immediate itself is always produced
//   sign-extended to 64 bits.
// Ports:
//   inst  in   32-bit instruction word
//   res   out  decode result {imm, fmt, illegal}
// ----------------------------------------------------------------------------
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0] inst,
  output dec_res_t    res
);

  localparam bit IS_RV64 = (XLEN == 64);

  imm_fmt_e fmt;
  logic     illegal;
  logic     sgn;

  assign sgn = inst[31];

  // Format selection from the major opcode.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first; a path that leaves it unassigned would infer a latch.
    fmt     = FMT_NONE;
    illegal = 1'b0;
    unique case (inst[6:0])
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: fmt = FMT_I;
      OP_STORE:                            fmt = FMT_S;
      OP_BRANCH:                           fmt = FMT_B;
      OP_LUI, OP_AUIPC:                    fmt = FMT_U;
      OP_JAL:                              fmt = FMT_J;
      OP_OP:                               fmt = FMT_NONE;
      OP_IMM32: begin
        if (IS_RV64) fmt = FMT_I;
        else         illegal = 1'b1;
      end
      OP_OP32: begin
        if (!IS_RV64) illegal = 1'b1;
      end
      default:                             illegal = 1'b1;
    endcase
  end

  // Bit-field assembly; each format sign-extends from inst[31].
  always_comb begin
    res.fmt     = fmt;
    res.illegal = illegal;
    res.imm     = '0;
    unique case (fmt)
      FMT_I: res.imm = {{52{sgn}}, inst[31:20]};
      FMT_S: res.imm = {{52{sgn}}, inst[31:25], inst[11:7]};
      FMT_B: res.imm = {{51{sgn}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      FMT_U: res.imm = {{32{sgn}}, inst[31:12], 12'b0};
      FMT_J: res.imm = {{43{sgn}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: res.imm = '0;
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// ----------------------------------------------------------------------------
// imm_gen_pipe
// One-cycle pipelined RISC-V immediate generator with a valid/ready input,
// a valid/ready output and a two-entry output skid buffer (main + skid), so
// in_ready is a pure function of registered state while sustaining one
// result per cycle.
// Parameters:
//   XLEN   immediate width, 32 or 64
//   TAG_W  width of the sideband tag carried with each instruction
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake; in_inst, in_tag payload
//   out_valid/out_ready   output handshake
//   out_imm/fmt/illegal   decode result of the oldest buffered instruction
//   out_tag               tag of that instruction
//   illegal_cnt           saturating count of accepted illegal instructions
// ----------------------------------------------------------------------------
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag,
  output logic [15:0]      illegal_cnt
);

  dec_res_t dec;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .inst (in_inst),
    .res  (dec)
  );

  // The decoder always sign-extends to 64 bits; a 32-bit pipeline keeps only
  // the low word, the rest is redundant copies of the sign bit.
  if (XLEN < IMM_MAX_W) begin : g_narrow
    logic unused_imm_hi;
    assign unused_imm_hi = ^dec.imm[IMM_MAX_W-1:XLEN];
  end

  occ_e state_q, state_d;

  logic accept, retire;
  logic load_main_in, load_main_skid, load_skid;

  logic [XLEN-1:0]  main_imm, skid_imm;
  imm_fmt_e         main_fmt, skid_fmt;
  logic             main_ill, skid_ill;
  logic [TAG_W-1:0] main_tag, skid_tag;
  logic [15:0]      cnt_q;

  assign in_ready  = (state_q != OCC_TWO);
  assign out_valid = (state_q != OCC_EMPTY);
  assign accept    = in_valid & in_ready;
  assign retire    = out_valid & out_ready;

  // Occupancy next-state and buffer steering.
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    unique case (state_q)
      OCC_EMPTY: begin
        if (accept) begin
          state_d      = OCC_ONE;
          load_main_in = 1'b1;
        end
      end
      OCC_ONE: begin
        if (accept && !retire) begin
          state_d   = OCC_TWO;
          load_skid = 1'b1;
        end else if (accept && retire) begin
          load_main_in = 1'b1;
        end else if (retire) begin
          state_d = OCC_EMPTY;
        end
      end
      OCC_TWO: begin
        // in_ready is low here, so only a retire can happen.
        if (retire) begin
          state_d        = OCC_ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_d = OCC_EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= OCC_EMPTY;
    else        state_q <= state_d;
  end

  // NOTE: both buffer entries are cleared on reset, not just the valid
  // state, so no stale payload is observable after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_imm <= '0;
      main_fmt <= FMT_NONE;
      main_ill <= 1'b0;
      main_tag <= '0;
    end else if (load_main_in) begin
      main_imm <= dec.imm[XLEN-1:0];
      main_fmt <= dec.fmt;
      main_ill <= dec.illegal;
      main_tag <= in_tag;
    end else if (load_main_skid) begin
      main_imm <= skid_imm;
      main_fmt <= skid_fmt;
      main_ill <= skid_ill;
      main_tag <= skid_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_imm <= '0;
      skid_fmt <= FMT_NONE;
      skid_ill <= 1'b0;
      skid_tag <= '0;
    end else if (load_skid) begin
      skid_imm <= dec.imm[XLEN-1:0];
      skid_fmt <= dec.fmt;
      skid_ill <= dec.illegal;
      skid_tag <= in_tag;
    end
  end

  // Counts at acceptance, independent of when the result retires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (accept && dec.illegal && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign out_imm     = main_imm;
  assign out_fmt     = main_fmt;
  assign out_illegal = main_ill;
  assign out_tag     = main_tag;
  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// ----------------------------------------------------------------------------
// tb_imm_gen_pipe
// Drives a 32-bit and a 64-bit instance of imm_gen_pipe with the same
// instruction stream. A driver process feeds a pending queue into the input
// handshake and pushes each accepted vector onto a scoreboard; a monitor
// process pops the scoreboard whenever a result retires and compares it,
// and also checks the handshake flags and illegal counter every cycle.
// ----------------------------------------------------------------------------
module tb_imm_gen_pipe;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] tag;
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [2:0]  fmt32;
    logic [2:0]  fmt64;
    logic        ill32;
    logic        ill64;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [31:0] in_tag;
  logic        out_ready;

  logic        in_ready32, out_valid32, out_illegal32;
  logic [31:0] out_imm32, out_tag32;
  logic [2:0]  out_fmt32;
  logic [15:0] cnt32;

  logic        in_ready64, out_valid64, out_illegal64;
  logic [63:0] out_imm64;
  logic [31:0] out_tag64;
  logic [2:0]  out_fmt64;
  logic [15:0] cnt64;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
    .in_inst(in_inst), .in_tag(in_tag), .out_valid(out_valid32),
    .out_ready(out_ready), .out_imm(out_imm32), .out_fmt(out_fmt32),
    .out_illegal(out_illegal32), .out_tag(out_tag32), .illegal_cnt(cnt32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
    .in_inst(in_inst), .in_tag(in_tag), .out_valid(out_valid64),
    .out_ready(out_ready), .out_imm(out_imm64), .out_fmt(out_fmt64),
    .out_illegal(out_illegal64), .out_tag(out_tag64), .illegal_cnt(cnt64)
  );

  always #5 clk = ~clk;

  vec_t vtab [16];
  vec_t pending [$];
  vec_t sb [$];

  int          n_vec  = 0;
  int          n_miss = 0;
  int          n_acc  = 0;
  int          n_ret  = 0;
  int          n_stall = 0;
  int          max_occ = 0;
  logic [15:0] exp_cnt32 = '0;
  logic [15:0] exp_cnt64 = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] inst, input logic [31:0] imm32,
                              input logic [63:0] imm64, input logic [2:0] f32,
                              input logic [2:0] f64, input logic i32, input logic i64);
    vec_t v;
    v.inst = inst; v.tag = '0; v.imm32 = imm32; v.imm64 = imm64;
    v.fmt32 = f32; v.fmt64 = f64; v.ill32 = i32; v.ill64 = i64;
    return v;
  endfunction

  task automatic push(input int idx, input logic [31:0] tag);
    vec_t v;
    v = vtab[idx];
    v.tag = tag;
    pending.push_back(v);
  endtask

  task automatic wait_drain(input int budget);
    int b = 0;
    while ((pending.size() != 0 || sb.size() != 0) && b < budget) begin
      @(posedge clk);
      b++;
    end
    #1;
    check("drain_outstanding", 64'(pending.size() + sb.size()), 64'd0);
  endtask

  // Driver: presents the head of the pending queue; an accept seen before an
  // edge moves that vector onto the scoreboard just after the edge.
  initial begin
    bit   acc;
    vec_t v;
    in_valid = 1'b0;
    in_inst  = '0;
    in_tag   = '0;
    forever begin
      @(negedge clk);
      acc = in_valid && in_ready32 && rst_n;
      if (in_valid && !in_ready32 && rst_n) n_stall++;
      @(posedge clk);
      #1;
      if (acc && rst_n && pending.size() != 0) begin
        v = pending.pop_front();
        sb.push_back(v);
        n_acc++;
        if (v.ill32 && exp_cnt32 != 16'hFFFF) exp_cnt32++;
        if (v.ill64 && exp_cnt64 != 16'hFFFF) exp_cnt64++;
      end
      if (pending.size() != 0) begin
        in_valid = 1'b1;
        in_inst  = pending[0].inst;
        in_tag   = pending[0].tag;
      end else begin
        in_valid = 1'b0;
      end
    end
  end

  // Monitor: per-cycle handshake/counter checks and in-order result compare.
  initial begin
    vec_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (sb.size() > max_occ) max_occ = sb.size();
        check("in_ready32",  64'(in_ready32),  64'(sb.size() < 2));
        check("in_ready64",  64'(in_ready64),  64'(sb.size() < 2));
        check("out_valid32", 64'(out_valid32), 64'(sb.size() > 0));
        check("out_valid64", 64'(out_valid64), 64'(sb.size() > 0));
        check("illegal_cnt32", 64'(cnt32), 64'(exp_cnt32));
        check("illegal_cnt64", 64'(cnt64), 64'(exp_cnt64));
        if (out_valid32 && out_ready && sb.size() != 0) begin
          e = sb.pop_front();
          n_ret++;
          check("imm32",     64'(out_imm32),     64'(e.imm32));
          check("fmt32",     64'(out_fmt32),     64'(e.fmt32));
          check("illegal32", 64'(out_illegal32), 64'(e.ill32));
          check("tag32",     64'(out_tag32),     64'(e.tag));
          check("imm64",     out_imm64,          e.imm64);
          check("fmt64",     64'(out_fmt64),     64'(e.fmt64));
          check("illegal64", 64'(out_illegal64), 64'(e.ill64));
          check("tag64",     64'(out_tag64),     64'(e.tag));
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_acc, base_ret, base_stall, waited;

    //              inst          imm32         imm64                  f32   f64   i32   i64
    vtab[0]  = mk(32'hFFC12083, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd1, 3'd1, 1'b0, 1'b0); // lw
    vtab[1]  = mk(32'hFE112E23, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd2, 3'd2, 1'b0, 1'b0); // sw
    vtab[2]  = mk(32'hFE000EE3, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd3, 3'd3, 1'b0, 1'b0); // beq -4
    vtab[3]  = mk(32'h0080006F, 32'h00000008, 64'h0000000000000008, 3'd5, 3'd5, 1'b0, 1'b0); // jal +8
    vtab[4]  = mk(32'h800000B7, 32'h80000000, 64'hFFFFFFFF80000000, 3'd4, 3'd4, 1'b0, 1'b0); // lui
    vtab[5]  = mk(32'h7FF00093, 32'h000007FF, 64'h00000000000007FF, 3'd1, 3'd1, 1'b0, 1'b0); // addi 2047
    vtab[6]  = mk(32'h12345097, 32'h12345000, 64'h0000000012345000, 3'd4, 3'd4, 1'b0, 1'b0); // auipc
    vtab[7]  = mk(32'h00000033, 32'h00000000, 64'h0000000000000000, 3'd0, 3'd0, 1'b0, 1'b0); // add
    vtab[8]  = mk(32'hFFF0009B, 32'h00000000, 64'hFFFFFFFFFFFFFFFF, 3'd0, 3'd1, 1'b1, 1'b0); // addiw
    vtab[9]  = mk(32'h0000003B, 32'h00000000, 64'h0000000000000000, 3'd0, 3'd0, 1'b1, 1'b0); // addw
    vtab[10] = mk(32'hFFFFFFFF, 32'h00000000, 64'h0000000000000000, 3'd0, 3'd0, 1'b1, 1'b1); // bad opcode
    vtab[11] = mk(32'hFFF00067, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd1, 3'd1, 1'b0, 1'b0); // jalr -1
    vtab[12] = mk(32'h80002073, 32'hFFFFF800, 64'hFFFFFFFFFFFFF800, 3'd1, 3'd1, 1'b0, 1'b0); // csr
    vtab[13] = mk(32'h7E000FA3, 32'h000007FF, 64'h00000000000007FF, 3'd2, 3'd2, 1'b0, 1'b0); // sb +2047
    vtab[14] = mk(32'h000000E3, 32'h00000800, 64'h0000000000000800, 3'd3, 3'd3, 1'b0, 1'b0); // beq +2048
    vtab[15] = mk(32'hFFFFF06F, 32'hFFFFFFFE, 64'hFFFFFFFFFFFFFFFE, 3'd5, 3'd5, 1'b0, 1'b0); // jal -2

    // Reset values.
    rst_n     = 1'b0;
    out_ready = 1'b0;
    #23;
    check("rst_out_valid32", 64'(out_valid32), 64'd0);
    check("rst_out_valid64", 64'(out_valid64), 64'd0);
    check("rst_out_imm64",   out_imm64,        64'd0);
    check("rst_out_tag32",   64'(out_tag32),   64'd0);
    check("rst_out_fmt32",   64'(out_fmt32),   64'd0);
    check("rst_cnt32",       64'(cnt32),       64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_rst", 64'(in_ready32), 64'd1);

    // Directed decode table, free-flowing output.
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) push(i, 32'h100 + i);
    wait_drain(200);
    check("cnt32_after_table", 64'(cnt32), 64'd3);
    check("cnt64_after_table", 64'(cnt64), 64'd1);

    // Backpressure: only two of four enter, head stays stable.
    @(posedge clk); #1;
    out_ready = 1'b0;
    base_acc  = n_acc;
    for (int i = 0; i < 4; i++) push(i, 32'hA0 + i);
    repeat (6) @(negedge clk);
    check("bp_accepted",   64'(n_acc - base_acc), 64'd2);
    check("bp_in_ready",   64'(in_ready32),       64'd0);
    check("bp_head_tag",   64'(out_tag32),        64'hA0);
    repeat (3) @(negedge clk);
    check("bp_hold_accepted", 64'(n_acc - base_acc), 64'd2);
    check("bp_hold_tag",   64'(out_tag32),        64'hA0);
    check("bp_hold_imm",   64'(out_imm32),        64'hFFFFFFFC);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain(50);

    // Throughput: 100 back-to-back, one outstanding at a time.
    @(posedge clk); #1;
    base_ret   = n_ret;
    base_stall = n_stall;
    max_occ    = 0;
    for (int i = 0; i < 100; i++) push(i % 16, 32'h1000 + i);
    wait_drain(300);
    check("tp_retired", 64'(n_ret - base_ret),     64'd100);
    check("tp_stalls",  64'(n_stall - base_stall), 64'd0);
    check("tp_max_occ", 64'(max_occ),              64'd1);

    // Counter saturation.
    for (int i = 0; i < 70000; i++) push(10, i);
    wait_drain(71000);
    check("sat_cnt32", 64'(cnt32), 64'hFFFF);
    check("sat_cnt64", 64'(cnt64), 64'hFFFF);

    // Reset while two entries are buffered.
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(i + 4, 32'hB0 + i);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (in_ready32 && waited < 20);
    check("two_reached", 64'(in_ready32), 64'd0);
    #2;
    rst_n = 1'b0;
    pending.delete();
    sb.delete();
    exp_cnt32 = '0;
    exp_cnt64 = '0;
    #1;
    check("midrst_out_valid32", 64'(out_valid32), 64'd0);
    check("midrst_out_valid64", 64'(out_valid64), 64'd0);
    check("midrst_cnt32",       64'(cnt32),       64'd0);
    check("midrst_cnt64",       64'(cnt64),       64'd0);
    check("midrst_imm32",       64'(out_imm32),   64'd0);
    check("midrst_tag64",       64'(out_tag64),   64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready",  64'(in_ready32),  64'd1);
    check("post_rst_out_valid", 64'(out_valid32), 64'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    push(4, 32'hC0);
    push(8, 32'hC1);
    wait_drain(50);
    check("post_rst_cnt32", 64'(cnt32), 64'd1);
    check("post_rst_cnt64", 64'(cnt64), 64'd0);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter XLEN, default 32, immediate/output width; legal values 32 and 64 only.
REQ-002 Parameter TAG_W, default 32, width of sideband tag (typically PC) carried alongside each instruction.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  upstream holds an instruction.
REQ-006 in_ready  output  1  block accepts the instruction this cycle.
REQ-007 in_inst  input  32  RV32/RV64 instruction word.
REQ-008 in_tag  input  TAG_W  sideband, returned unchanged with the result.
REQ-009 out_valid  output  1  result present.
REQ-010 out_ready  input  1  downstream consumes the result this cycle.
REQ-011 out_imm  output  XLEN  sign-extended immediate.
REQ-012 out_fmt  output  3  format code: NONE=0, I=1, S=2, B=3, U=4, J=5.
REQ-013 out_illegal  output  1  opcode not recognised.
REQ-014 out_tag  output  TAG_W  tag of the instruction in out_imm.
REQ-015 illegal_cnt  output  16  saturating count of accepted illegal instructions.

Function
REQ-016 Transfer occurs on in_valid&in_ready (accept) or out_valid&out_ready (retire); no other event changes state.
REQ-017 Decode by inst[6:0]: 0000011, 0010011, 1100111, 1110011 -> I; 0100011 -> S; 1100011 -> B; 0110111, 0010111 -> U; 1101111 -> J; 0110011 -> NONE; 0011011 -> I and 0111011 -> NONE only when XLEN=64.
REQ-018 Any other opcode, or an RV64-only opcode with XLEN=32, gives fmt NONE, imm 0, illegal 1.
REQ-019 Immediate bit fields: I = inst[31:20]; S = inst[31:25],inst[11:7]; B = inst[31],inst[7],inst[30:25],inst[11:8],0; J = inst[31],inst[19:12],inst[20],inst[30:21],0; U = inst[31:12] followed by 12 zero bits.
REQ-020 Every format sign-extends from inst[31] to XLEN; NONE gives 0.
REQ-021 Latency is exactly 1 cycle: an instruction accepted at edge N is visible on the outputs after edge N.
REQ-022 Output stage is a 2-entry skid buffer (main register + skid register) giving full throughput with registered in_ready.
REQ-023 Occupancy FSM has states EMPTY, ONE, TWO. in_ready=1 in EMPTY and ONE, 0 in TWO. out_valid=1 in ONE and TWO.
REQ-024 EMPTY: accept -> ONE.
REQ-025 ONE: accept without retire -> TWO, new entry goes to skid. Accept with retire -> ONE, new entry goes to main. Retire only -> EMPTY.
REQ-026 TWO: retire -> ONE, skid moves to main. No retire -> hold.
REQ-027 Results leave in acceptance order; outputs stay stable while out_valid=1 and out_ready=0.
REQ-028 illegal_cnt increments by 1 on each accepted illegal instruction and saturates at 16'hFFFF; it counts at acceptance, independent of retire.
REQ-029 in_inst and in_tag are ignored when no accept occurs; out_* payload is don't-care when out_valid=0.

Reset
REQ-030 While rst_n=0: FSM in EMPTY, out_valid=0, out_imm=0, out_fmt=0, out_illegal=0, out_tag=0, illegal_cnt=0, skid contents=0.
REQ-031 Reset asserted mid-operation discards all buffered entries immediately; no partial result is presented after release.
REQ-032 in_ready=1 from the first cycle after rst_n deasserts.

Structure
REQ-033 Package imm_gen_pkg holds the imm_fmt_e enum (3-bit), the opcode localparams and the decode result struct {imm, fmt, illegal}.
REQ-034 Sub-module imm_decode (combinational, parametrised by XLEN) produces the decode result struct; imm_gen_pipe instantiates it once and adds the skid buffer, FSM and counter.

Verification
REQ-035 Decode: lw with inst 32'hFFC12083 -> imm FFFFFFFC, fmt I. sw with inst 32'hFE112E23 -> imm FFFFFFFC, fmt S.
REQ-036 Decode: beq with B-immediate -4 -> imm FFFFFFFC. jal with 32'h0080006F -> imm 00000008. lui with 32'h800000B7 -> imm 80000000.
REQ-037 With XLEN=64: lui with 32'h800000B7 -> imm FFFFFFFF80000000. 0011011 accepted as legal. With XLEN=32: 0011011 -> illegal=1 and illegal_cnt increments.
REQ-038 Backpressure: stream 4 instructions with out_ready=0 -> 2 accepted, in_ready drops to 0 after the second, outputs stable. Raise out_ready -> all 4 retire in order with tags intact.
REQ-039 Throughput: in_valid=out_ready=1 for 100 cycles -> 100 results, 1-cycle latency, FSM stays in ONE.
REQ-040 Counter: 70000 illegal opcodes -> illegal_cnt=FFFF. Reset asserted while in TWO -> out_valid=0 and count=0 within the same cycle.
